// File: rtl/posit_encoder_if.sv
// posit_encoder_if
// Bundles the two valid/ready streams of the posit encoder.
//   Input stream : in_valid, in_ready, in_sign, in_scale, in_frac,
//                  in_sticky, in_zero, in_nar
//   Output stream: out_valid, out_ready, out_posit
// Modports:
//   master - the surrounding datapath (drives triples, accepts results)
//   slave  - the encoder itself
`timescale 1ns/1ps
interface posit_encoder_if #(
    parameter int N  = 32,
    parameter int ES = 4,
    parameter int SW = $clog2(N) + ES + 2
);
    logic                 in_valid;
    logic                 in_ready;
    logic                 in_sign;
    logic signed [SW-1:0] in_scale;
    logic [N-1:0]         in_frac;
    logic                 in_sticky;
    logic                 in_zero;
    logic                 in_nar;
    logic                 out_valid;
    logic                 out_ready;
    logic [N-1:0]         out_posit;

    modport master (
        output in_valid, in_sign, in_scale, in_frac, in_sticky, in_zero, in_nar,
        output out_ready,
        input  in_ready, out_valid, out_posit
    );

    modport slave (
        input  in_valid, in_sign, in_scale, in_frac, in_sticky, in_zero, in_nar,
        input  out_ready,
        output in_ready, out_valid, out_posit
    );
endinterface

// File: rtl/posit_encoder.sv
// posit_encoder
// Packs a decoded (sign, scale, fraction) triple into an N-bit posit word:
// regime construction, rounding, saturation to maxpos/minpos, zero/NaR
// specials and two's-complement negation. Two register stages, one result
// per cycle, stalls cleanly under downstream backpressure.
//
// Ports:
//   clk    - clock, all state on the rising edge
//   rst_n  - asynchronous active-low reset (clears stage valids and out_posit)
//   bus    - posit_encoder_if.slave: input triple stream and output posit stream
//
// Build option:
//   POSIT_ENC_RNE_EN - when defined, round-to-nearest-even; otherwise the
//                      magnitude is truncated (guard/sticky ignored).
`timescale 1ns/1ps
module posit_encoder #(
    parameter int N  = 32,
    parameter int ES = 4,
    parameter int SW = $clog2(N) + ES + 2
) (
    input  logic           clk,
    input  logic           rst_n,
    posit_encoder_if.slave bus
);
    // Shift window: regime seed + exponent + fraction, with N zero bits of
    // headroom below so nothing shifted out is lost before guard/sticky.
    localparam int BW = 2 + ES + 2 * N;
    localparam logic signed [SW-1:0] K_SAT_HI = SW'(N - 2);
    localparam logic signed [SW-1:0] K_SAT_LO = SW'(-(N - 1));
    localparam logic [N-2:0] MAG_MAX = '1;
    localparam logic [N-2:0] MAG_MIN = (N-1)'(1);

`ifdef POSIT_ENC_RNE_EN
    function automatic logic [N-2:0] round_mag(input logic [N-2:0] mag,
                                               input logic guard,
                                               input logic sticky);
        logic [N-1:0] inc;
        inc = {1'b0, mag} + N'(guard & (mag[0] | sticky));
        // A carry into the sign position would leave the positive range.
        return inc[N-1] ? MAG_MAX : inc[N-2:0];
    endfunction
`else
    function automatic logic [N-2:0] round_mag(input logic [N-2:0] mag);
        return mag;
    endfunction
`endif

    function automatic logic [N-2:0] saturate(input logic [N-2:0] mag,
                                              input logic sat_hi,
                                              input logic sat_lo);
        if (sat_hi)
            return MAG_MAX;
        else if (sat_lo || mag == '0)
            return MAG_MIN;
        return mag;
    endfunction

    function automatic logic [N-1:0] apply_sign(input logic [N-2:0] mag,
                                                input logic sign);
        logic [N-1:0] full;
        full = {1'b0, mag};
        return sign ? -full : full;
    endfunction

    logic s1_load, s2_load;
    logic vld_p1, vld_p2;

    // Stage 1 combinational: regime/exponent build and alignment
    logic signed [SW-1:0] k;
    logic [ES-1:0]        e;
    logic [SW-1:0]        shamt;
    logic [1:0]           seed;
    logic signed [BW-1:0] body;
    logic signed [BW-1:0] body_sh;

    assign k = bus.in_scale >>> ES;
    assign e = bus.in_scale[ES-1:0];
    // Seed "10" for k >= 0 and "01" for k < 0; the arithmetic shift then
    // replicates the seed MSB, giving (k+1) ones + 0 or (-k) zeros + 1.
    // The shift count for negative k is -k-1, i.e. ~k.
    assign seed    = k[SW-1] ? 2'b01 : 2'b10;
    assign shamt   = k[SW-1] ? ~k : k;
    assign body    = {seed, e, bus.in_frac, {N{1'b0}}};
    assign body_sh = body >>> shamt;

    logic [N-2:0] mag_p1;
    logic         guard_p1, sticky_p1;
    logic         sign_p1, zero_p1, nar_p1, sat_hi_p1, sat_lo_p1;
    logic [N-1:0] posit_p2;

    assign s2_load      = !vld_p2 || bus.out_ready;
    assign s1_load      = !vld_p1 || s2_load;
    assign bus.in_ready = s1_load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            if (s1_load) vld_p1 <= bus.in_valid;
            if (s2_load) vld_p2 <= vld_p1;
        end
    end

    // Stage 1 register: truncated magnitude, rounding bits, special flags
    always_ff @(posedge clk) begin
        if (s1_load && bus.in_valid) begin
            mag_p1    <= body_sh[BW-1 -: N-1];
            guard_p1  <= body_sh[BW-N];
            sticky_p1 <= (|body_sh[BW-N-1:0]) | bus.in_sticky;
            sign_p1   <= bus.in_sign;
            nar_p1    <= bus.in_nar;
            zero_p1   <= bus.in_zero;
            sat_hi_p1 <= (k >= K_SAT_HI);
            sat_lo_p1 <= (k <= K_SAT_LO);
        end
    end

    // Stage 2 combinational: round, saturate, negate, specials
    logic [N-2:0] mag_rnd, mag_sat;
    logic [N-1:0] posit_d;

`ifdef POSIT_ENC_RNE_EN
    assign mag_rnd = round_mag(mag_p1, guard_p1, sticky_p1);
`else
    logic unused_round;
    assign unused_round = guard_p1 ^ sticky_p1;
    assign mag_rnd = round_mag(mag_p1);
`endif

    always_comb begin
        mag_sat = saturate(mag_rnd, sat_hi_p1, sat_lo_p1);
        posit_d = apply_sign(mag_sat, sign_p1);
        if (nar_p1)
            posit_d = {1'b1, {(N-1){1'b0}}};
        else if (zero_p1)
            posit_d = '0;
    end

    // Stage 2 register: output word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            posit_p2 <= '0;
        else if (s2_load && vld_p1)
            posit_p2 <= posit_d;
    end

    assign bus.out_valid = vld_p2;
    assign bus.out_posit = posit_p2;
endmodule

// File: tb/tb_posit_encoder.sv
`timescale 1ns/1ps
module tb_posit_encoder;
    localparam int N  = 32;
    localparam int ES = 4;
    localparam int SW = $clog2(N) + ES + 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    posit_encoder_if #(.N(N), .ES(ES), .SW(SW)) bus ();
    posit_encoder #(.N(N), .ES(ES), .SW(SW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [31:0] posit;
        int          cyc;
        bit          lat;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   n_out = 0;
    int   rdy_mode = 0;     // 0: always ready, 1: random, 2: rdy_manual
    bit   rdy_manual = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Golden model: lays the posit bits out one by one in a queue.
    function automatic logic [31:0] ref_encode(input bit sign, input int scale,
                                               input logic [31:0] frac, input bit sticky,
                                               input bit zero, input bit nar);
        bit bits[$];
        int k, e;
        logic [31:0] mag;
        bit g, s, rnd;
        if (nar) return 32'h8000_0000;
        if (zero) return 32'h0;
        k = (scale >= 0) ? scale / 16 : -((-scale + 15) / 16);
        e = scale - 16 * k;
        if (k >= N - 2) mag = 32'h7FFF_FFFF;
        else if (k <= -(N - 1)) mag = 32'h1;
        else begin
            bits.push_back(1'b0);
            if (k >= 0) begin
                repeat (k + 1) bits.push_back(1'b1);
                bits.push_back(1'b0);
            end else begin
                repeat (-k) bits.push_back(1'b0);
                bits.push_back(1'b1);
            end
            for (int i = ES - 1; i >= 0; i--) bits.push_back(e[i]);
            for (int i = 31; i >= 0; i--) bits.push_back(frac[i]);
            mag = 32'h0;
            for (int i = 0; i < 32; i++) mag = {mag[30:0], bits[i]};
            g = bits[32];
            s = sticky;
            for (int i = 33; i < bits.size(); i++) s = s | bits[i];
`ifdef POSIT_ENC_RNE_EN
            rnd = g && (mag[0] || s);
`else
            rnd = 1'b0 & (g | s);
`endif
            mag = mag + {31'b0, rnd};
            if (mag > 32'h7FFF_FFFF) mag = 32'h7FFF_FFFF;
        end
        return sign ? (~mag + 32'h1) : mag;
    endfunction

    // Issue one triple (called at posedge+1); pushes expectation on accept.
    task automatic send(input bit sign, input int scale, input logic [31:0] frac,
                        input bit sticky, input bit zero, input bit nar,
                        input logic [31:0] exp);
        bit acc;
        int waitc;
        exp_t it;
        bus.in_valid  = 1'b1;
        bus.in_sign   = sign;
        bus.in_scale  = scale[SW-1:0];
        bus.in_frac   = frac;
        bus.in_sticky = sticky;
        bus.in_zero   = zero;
        bus.in_nar    = nar;
        acc = 1'b0;
        waitc = 0;
        while (!acc && waitc < 1000) begin
            @(negedge clk);
            acc = bus.in_ready;
            if (acc) begin
                it.posit = exp;
                it.cyc   = cyc;
                it.lat   = (rdy_mode == 0);
                exp_q.push_back(it);
            end
            @(posedge clk);
            #1;
            waitc++;
        end
        if (!acc) chk("accept_timeout", 32'(acc), 32'h1);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        chk("drain", exp_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic send_rand(output logic [31:0] x);
        bit sign, sticky, zero, nar;
        int scale;
        logic [31:0] frac, mask;
        sign   = 1'($urandom_range(0, 1));
        scale  = ($urandom_range(0, 99) < 70) ? int'($urandom_range(0, 960)) - 480
                                              : int'($urandom_range(0, 2047)) - 1024;
        frac   = $urandom();
        if ($urandom_range(0, 2) == 0) begin
            mask = (32'h1 << $urandom_range(0, 31)) - 32'h1;
            frac = frac & ~mask;
        end
        sticky = ($urandom_range(0, 3) == 0);
        zero   = ($urandom_range(0, 49) == 0);
        nar    = ($urandom_range(0, 49) == 0);
        x = ref_encode(sign, scale, frac, sticky, zero, nar);
        send(sign, scale, frac, sticky, zero, nar, x);
    endtask

    // out_ready driver
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = ($urandom_range(0, 3) != 0);
                default: bus.out_ready = rdy_manual;
            endcase
        end
    end

    // Monitor: pops and compares whenever a result transfers; checks hold under stall.
    bit          prev_stall = 1'b0;
    logic [31:0] prev_posit = 32'h0;
    always @(negedge clk) begin
        exp_t it;
        if (rst_n) begin
            if (prev_stall) begin
                chk("stall_valid", 32'(bus.out_valid), 32'h1);
                chk("stall_hold", bus.out_posit, prev_posit);
            end
            if (bus.out_valid && bus.out_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", bus.out_posit, 32'hxxxx_xxxx);
                end else begin
                    it = exp_q.pop_front();
                    chk("posit", bus.out_posit, it.posit);
                    if (it.lat) chk("latency", cyc - it.cyc, 2);
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_posit = bus.out_posit;
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] x;
        int   out0;
        bit   saw_block;
        bus.in_valid = 1'b0; bus.in_sign = 1'b0; bus.in_scale = '0; bus.in_frac = '0;
        bus.in_sticky = 1'b0; bus.in_zero = 1'b0; bus.in_nar = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_out_valid", 32'(bus.out_valid), 32'h0);
        chk("reset_out_posit", bus.out_posit, 32'h0);
        chk("reset_in_ready", 32'(bus.in_ready), 32'h1);

        // Directed values, out_ready held high
        send(0, 0,    32'h0, 0, 0, 0, 32'h4000_0000);
        send(0, 16,   32'h0, 0, 0, 0, 32'h6000_0000);
        send(0, -1,   32'h0, 0, 0, 0, 32'h3E00_0000);
        send(1, 0,    32'h0, 0, 0, 0, 32'hC000_0000);
        send(0, 0,    32'h40, 0, 0, 0, 32'h4000_0000);
`ifdef POSIT_ENC_RNE_EN
        send(0, 0,    32'hC0, 0, 0, 0, 32'h4000_0002);
        send(0, 0,    32'h40, 1, 0, 0, 32'h4000_0001);
`else
        send(0, 0,    32'hC0, 0, 0, 0, 32'h4000_0001);
        send(0, 0,    32'h40, 1, 0, 0, 32'h4000_0000);
`endif
        send(0, 640,  32'h0, 0, 0, 0, 32'h7FFF_FFFF);
        send(0, -640, 32'h0, 0, 0, 0, 32'h0000_0001);
        send(1, 640,  32'h0, 0, 0, 0, 32'h8000_0001);
        send(1, 5,    32'h1234, 0, 1, 0, 32'h0000_0000);
        send(1, 5,    32'h1234, 0, 1, 1, 32'h8000_0000);
        send(0, 464,  32'h0, 0, 0, 0, 32'h7FFF_FFFE);
        send(0, 480,  32'h0, 0, 0, 0, 32'h7FFF_FFFF);
        send(0, -480, 32'h0, 0, 0, 0, 32'h0000_0001);
        send(1, -481, 32'hFFFF_FFFF, 1, 0, 0, 32'hFFFF_FFFF);
        wait_drain();

        // Backpressure: 8 back-to-back, out_ready low for a few cycles
        rdy_manual = 1'b1;
        rdy_mode   = 2;
        out0       = n_out;
        saw_block  = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++) send_rand(x);
            end
            begin
                for (int c = 0; c < 14; c++) begin
                    rdy_manual = !(c >= 3 && c <= 6);
                    @(negedge clk);
                    if (c >= 3 && c <= 8 && !bus.in_ready) saw_block = 1'b1;
                    @(posedge clk);
                    #1;
                end
            end
        join
        wait_drain();
        chk("bp_in_ready_drop", 32'(saw_block), 32'h1);
        chk("bp_count", n_out - out0, 8);

        // Reset with both stages full
        rdy_manual = 1'b0;
        @(posedge clk);
        #1;
        send(0, 32, 32'h0, 0, 0, 0, 32'h7000_0000);
        send(1, 32, 32'h0, 0, 0, 0, 32'h9000_0000);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_async_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_async_posit", bus.out_posit, 32'h0);
        exp_q.delete();
        rdy_mode = 0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'h1);
        chk("post_rst_valid", 32'(bus.out_valid), 32'h0);
        chk("post_rst_posit", bus.out_posit, 32'h0);
        send(0, 16, 32'h0, 0, 0, 0, 32'h6000_0000);
        wait_drain();

        // Random traffic with random backpressure
        rdy_mode = 1;
        for (int i = 0; i < 10000; i++) send_rand(x);
        rdy_mode = 0;
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/posit_encoder.md
# posit_encoder

Pipelined posit encoder: takes a decoded (sign, scale, fraction) triple and emits the packed N-bit posit word, including regime construction, round-to-nearest-even, saturation and two's-complement negation. It is the inverse of the posit decode front end and sits at the output of the posit arithmetic datapath (after add/normalise), feeding result collection through a valid/ready handshake. Two register stages, full throughput, backpressure-aware.

## Interface
- N, 32, posit word width
- ES, 4, exponent field width
- SW, $clog2(N)+ES+2, signed scale width
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  input triple valid
- in_ready  out  1  encoder can accept this cycle
- in_sign  in  1  1 = negative
- in_scale  in  SW  signed total scale: value = 2^scale × 1.frac
- in_frac  in  N  fraction after hidden bit, MSB-aligned
- in_sticky  in  1  OR of fraction bits discarded upstream
- in_zero  in  1  value is zero (overrides other fields)
- in_nar  in  1  value is NaR (overrides in_zero and other fields)
- out_valid  out  1  out_posit valid
- out_ready  in  1  downstream accepts
- out_posit  out  N  encoded posit

## Operation
- Transfer on a port occurs when valid & ready are both high on a rising clk edge.
- k = in_scale >>> ES (floor); e = in_scale & (2^ES−1).
- Regime: k ≥ 0 → (k+1) ones then a zero; k < 0 → (−k) zeros then a one. Terminator dropped when the regime fills N−1 bits.
- Magnitude = {0, regime, e, in_frac} truncated to N bits; guard = first dropped bit; sticky = OR(remaining dropped bits, in_sticky).
- Rounding (RNE): increment magnitude if guard & (lsb | sticky).
- Saturation: k ≥ N−2 → 0x7FFF…F (maxpos); k ≤ −(N−1) → 0x0000…1 (minpos). Non-zero inputs never round to 0 or to NaR; rounding overflow past maxpos clamps to maxpos.
- in_sign = 1 → out_posit = two's complement of magnitude.
- in_zero → all zeros; in_nar → 1 followed by N−1 zeros; sign ignored for both.
- Stage 1 (S1): regime/exponent build, shift, guard/sticky extraction, special-case flags. Stage 2 (S2): round, saturate, negate, register output.

## Timing
- Latency 2 cycles: triple accepted at edge t appears on out_posit with out_valid high after edge t+2 (no stall).
- Throughput 1 per cycle while out_ready = 1.
- Stage advance: S2 loads when empty or out_ready; S1 loads when empty or S2 loads this cycle; in_ready = S1 empty | S2 loads. in_ready is combinational from out_ready and stage valids, not from in_valid.
- Stall: out_valid & !out_ready → out_posit and out_valid held stable; pipeline holds at most 2 results, then in_ready = 0.
- Simultaneous output drain and input accept in the same cycle with both stages full: permitted, no bubble.
- Reset (any time, including mid-stream): out_valid = 0, out_posit = 0, stage valids = 0, in_ready = 1 on first cycle after deassert; in-flight data discarded.
- Data registers outside valid qualification are don't-care except out_posit, reset to 0.

## Configuration
- POSIT_ENC_RNE_EN defined: round-to-nearest-even as above.
- Not defined: truncation (no increment; guard/sticky ignored); saturation, specials and negation unchanged. S2 still registered, latency stays 2.

## Test plan
- N=32, ES=4, out_ready=1: scale 0 frac 0 → 0x40000000; scale 16 → 0x60000000; scale −1 → 0x3E000000; sign=1 scale 0 → 0xC0000000; each 2 cycles after accept.
- Rounding, scale 0: frac 0x00000040 → 0x40000000 (tie to even); frac 0x000000C0 → 0x40000002 with RNE_EN, 0x40000001 without; frac 0x00000040 + in_sticky → 0x40000001.
- Saturation/specials: scale 640 → 0x7FFFFFFF; scale −640 → 0x00000001; sign=1 scale 640 → 0x80000001; in_zero → 0x00000000; in_nar → 0x80000000.
- Backpressure: stream 8 back-to-back triples, out_ready low for cycles 3–6 → in_ready drops after 2 stalled entries, out_posit stable during stall, all 8 results in order, none lost or duplicated.
- Reset mid-stream: assert rst_n low with both stages full → out_valid 0 immediately (asynchronous), out_posit 0; after release, next accepted triple emerges after exactly 2 cycles, no stale output.
- Random: 10,000 random triples vs. golden encoder model, random out_ready → bit-exact match in order.
